// File: rtl/key_schedule_iter.sv
// Iterative AES key expansion: one schedule word per clock through a single SubWord path,
// with a registered round-key read port addressable at any time.
module key_schedule_iter #(
  parameter int KEY_WIDTH = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [KEY_WIDTH-1:0] key_i,
  input  logic [3:0]           rk_idx_i,
  output logic [127:0]         rk_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int NK    = KEY_WIDTH / 32;
  localparam int NR    = NK + 6;
  localparam int TOTAL = 4 * (NR + 1);

  localparam logic [5:0] NK_W     = 6'(NK);
  localparam logic [5:0] LAST_W   = 6'(TOTAL - 1);
  localparam logic [2:0] NK_M1    = 3'(NK - 1);
  localparam logic [3:0] NR_IDX   = 4'(NR);
  localparam bit         IS_256   = (NK == 8);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    sbox = SBOX[(255 - int'(x)) * 8 +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    sub_word = {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] x);
    rot_word = {x[23:0], x[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  logic [31:0] w_q [TOTAL];

  state_e       state_q, state_d;
  logic [5:0]   i_q, i_d;
  logic [2:0]   imod_q, imod_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [127:0] rk_q, rk_d;

  logic        start_ok_s;
  logic        wr_word_s;
  logic [5:0]  prev_idx_s, back_idx_s, base_s;
  logic [31:0] prev_s, back_s, sub_in_s, sub_out_s, temp_s, new_word_s;

  assign start_ok_s = start_i && (state_q != EXPAND);
  assign wr_word_s  = (state_q == EXPAND);

  // Datapath for the word being produced this cycle: w[i] = w[i-Nk] ^ temp.
  always_comb begin
    prev_idx_s = 6'd0;
    back_idx_s = 6'd0;
    if (state_q == EXPAND) begin
      prev_idx_s = i_q - 6'd1;
      back_idx_s = i_q - NK_W;
    end else begin
      prev_idx_s = 6'd0;
      back_idx_s = 6'd0;
    end
    prev_s    = w_q[prev_idx_s];
    back_s    = w_q[back_idx_s];
    sub_in_s  = (imod_q == 3'd0) ? rot_word(prev_s) : prev_s;
    sub_out_s = sub_word(sub_in_s);
    if (imod_q == 3'd0) begin
      temp_s = sub_out_s ^ {rcon_q, 24'h000000};
    end else if (IS_256 && (imod_q == 3'd4)) begin
      temp_s = sub_out_s;
    end else begin
      temp_s = prev_s;
    end
    new_word_s = back_s ^ temp_s;
  end

  // Round-key read mux; reads the schedule as it stands before this edge's writes.
  always_comb begin
    base_s = {rk_idx_i, 2'b00};
    if (rk_idx_i <= NR_IDX) begin
      rk_d = {w_q[base_s], w_q[base_s + 6'd1], w_q[base_s + 6'd2], w_q[base_s + 6'd3]};
    end else begin
      rk_d = 128'd0;
    end
  end

  // Schedule storage: key load on an accepted start, otherwise one derived word per EXPAND cycle.
  always_ff @(posedge clk_i) begin
    if (start_ok_s) begin
      for (int k = 0; k < NK; k++) begin
        w_q[k] <= key_i[KEY_WIDTH-1-32*k -: 32];
      end
    end else if (wr_word_s) begin
      w_q[i_q] <= new_word_s;
    end
  end

  // Next-state logic for the controller, counters and status flags.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    imod_d  = imod_q;
    rcon_d  = rcon_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = EXPAND;
          i_d     = NK_W;
          imod_d  = 3'd0;
          rcon_d  = 8'h01;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      EXPAND: begin
        i_d    = i_q + 6'd1;
        imod_d = (imod_q == NK_M1) ? 3'd0 : imod_q + 3'd1;
        if (imod_q == 3'd0) begin
          rcon_d = xtime(rcon_q);
        end else begin
          rcon_d = rcon_q;
        end
        if (i_q == LAST_W) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = EXPAND;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      i_q     <= 6'd0;
      imod_q  <= 3'd0;
      rcon_q  <= 8'h01;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rk_q    <= 128'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      imod_q  <= imod_d;
      rcon_q  <= rcon_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rk_q    <= rk_d;
    end
  end

  assign rk_o   = rk_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_key_schedule_iter.sv
// Directed bench for key_schedule_iter using the FIPS-197 expansion vectors
// for all three key sizes plus restart, ignored-start and mid-run reset cases.
module tb_key_schedule_iter;

  localparam logic [127:0] K128   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK2    = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] RK10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [191:0] K192   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [127:0] B_RK12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [255:0] K256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] C_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, start_b, start_c;
  logic [127:0] key_a;
  logic [191:0] key_b;
  logic [255:0] key_c;
  logic [3:0] idx_a, idx_b, idx_c;
  logic [127:0] rk_a, rk_b, rk_c;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  key_schedule_iter #(.KEY_WIDTH(128)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_a), .key_i(key_a),
    .rk_idx_i(idx_a), .rk_o(rk_a), .busy_o(busy_a), .done_o(done_a));

  key_schedule_iter #(.KEY_WIDTH(192)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_b), .key_i(key_b),
    .rk_idx_i(idx_b), .rk_o(rk_b), .busy_o(busy_b), .done_o(done_b));

  key_schedule_iter #(.KEY_WIDTH(256)) dut_c (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_c), .key_i(key_c),
    .rk_idx_i(idx_c), .rk_o(rk_c), .busy_o(busy_c), .done_o(done_c));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the start edge until done rises; optionally re-pulses start mid-run.
  task automatic wait_done(input int sel, input int pulse_at, output int cnt);
    logic d;
    cnt = 0;
    while (cnt < 200) begin
      tick();
      cnt++;
      if (sel == 0) start_a = (cnt == pulse_at - 1);
      d = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
      if (d) break;
    end
  endtask

  task automatic rd(input int sel, input logic [3:0] idx, input logic [127:0] exp, input string tag);
    if (sel == 0) idx_a = idx;
    else if (sel == 1) idx_b = idx;
    else idx_c = idx;
    tick();
    check(tag, (sel == 0) ? rk_a : (sel == 1) ? rk_b : rk_c, exp);
  endtask

  task automatic start_a_with(input logic [127:0] key);
    key_a = key;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("start_done_low", 128'(done_a), 128'd0);
    check("start_busy_high", 128'(busy_a), 128'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    key_a = '0; key_b = '0; key_c = '0;
    idx_a = 4'd0; idx_b = 4'd0; idx_c = 4'd0;
    #22;
    check("reset_rk", rk_a, 128'd0);
    check("reset_busy", 128'(busy_a), 128'd0);
    check("reset_done", 128'(done_a), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_no_done", 128'(done_a), 128'd0);

    // FIPS-197 AES-128 expansion
    start_a_with(K128);
    wait_done(0, 0, n);
    check("k128_latency", 128'(n), 128'd40);
    check("k128_busy_clear", 128'(busy_a), 128'd0);
    rd(0, 4'd1, RK1, "k128_rk1");
    rd(0, 4'd2, RK2, "k128_rk2");
    rd(0, 4'd10, RK10, "k128_rk10");
    rd(0, 4'd0, K128, "k128_rk0");
    rd(0, 4'd15, 128'd0, "k128_rk15_zero");
    rd(0, 4'd11, 128'd0, "k128_rk11_zero");

    // Back-to-back start in DONE while reading: old schedule comes out this edge
    idx_a = 4'd10;
    start_a_with(128'd0);
    check("restart_old_rk10", rk_a, RK10);
    wait_done(0, 0, n);
    check("zero_latency", 128'(n), 128'd40);
    rd(0, 4'd1, Z_RK1, "zero_rk1");
    rd(0, 4'd10, Z_RK10, "zero_rk10");

    // A start pulse during EXPAND is ignored
    start_a_with(K128);
    wait_done(0, 10, n);
    start_a = 1'b0;
    check("ignored_start_latency", 128'(n), 128'd40);
    rd(0, 4'd10, RK10, "ignored_start_rk10");

    // Asynchronous reset mid-expansion
    idx_a = 4'd1;
    start_a_with(K128);
    for (int k = 0; k < 19; k++) tick();
    check("mid_expand_rk1", rk_a, RK1);
    check("mid_expand_busy", 128'(busy_a), 128'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 128'(busy_a), 128'd0);
    check("async_rst_done", 128'(done_a), 128'd0);
    check("async_rst_rk", rk_a, 128'd0);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 45; k++) tick();
    check("post_rst_no_done", 128'(done_a), 128'd0);
    start_a_with(K128);
    wait_done(0, 0, n);
    check("post_rst_latency", 128'(n), 128'd40);
    rd(0, 4'd10, RK10, "post_rst_rk10");
    rd(0, 4'd0, K128, "post_rst_rk0");

    // FIPS-197 AES-192 expansion
    key_b = K192;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    wait_done(1, 0, n);
    check("k192_latency", 128'(n), 128'd46);
    rd(1, 4'd12, B_RK12, "k192_rk12");
    rd(1, 4'd0, K192[191:64], "k192_rk0");
    rd(1, 4'd13, 128'd0, "k192_rk13_zero");

    // FIPS-197 AES-256 expansion
    key_c = K256;
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    wait_done(2, 0, n);
    check("k256_latency", 128'(n), 128'd52);
    rd(2, 4'd14, C_RK14, "k256_rk14");
    rd(2, 4'd1, K256[127:0], "k256_rk1");
    rd(2, 4'd15, 128'd0, "k256_rk15_zero");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_schedule_iter.md
KEY_SCHEDULE_ITER -- requirements
Module: key_schedule_iter

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 128, AES cipher key width; legal values 128, 192 and 256; Nk = KEY_WIDTH/32; Nr = Nk+6; TOTAL = 4*(Nr+1) words.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start_i  input  1  request expansion of key_i.
REQ-005 SHALL have port key_i  input  KEY_WIDTH  cipher key; bits [KEY_WIDTH-1:KEY_WIDTH-32] are word w[0].
REQ-006 SHALL have port rk_idx_i  input  4  round-key index to read, 0..Nr.
REQ-007 SHALL have port rk_o  output  128  round key rk_idx_i, {w[4r],w[4r+1],w[4r+2],w[4r+3]}, w[4r] in the MSBs.
REQ-008 SHALL have port busy_o  output  1  expansion in progress.
REQ-009 SHALL have port done_o  output  1  schedule complete and rk_o valid for any index.

Function
REQ-010 SHALL implement the FSM states IDLE, EXPAND and DONE.
REQ-011 SHALL accept start_i only in IDLE or DONE; at that edge: write w[0..Nk-1] from key_i, set word counter i=Nk, set Rcon=0x01, clear done_o, set busy_o, go to EXPAND.
REQ-012 SHALL ignore start_i while in EXPAND; the current expansion SHALL continue unaffected.
REQ-013 SHALL, in EXPAND, compute and store exactly one word per clock: w[i] = w[i-Nk] XOR temp, where temp = w[i-1] transformed as follows:
- i mod Nk == 0: SubWord(RotWord(w[i-1])) XOR {Rcon,24'h0}.
- Nk == 8 and i mod Nk == 4: SubWord(w[i-1]).
- Otherwise: w[i-1] unchanged.
REQ-014 SHALL track i mod Nk with a wrapping counter (0..Nk-1), not a divider.
REQ-015 SHALL advance Rcon by GF(2^8) xtime (poly 0x11B) after each use: 01,02,04,08,10,20,40,80,1B,36.
REQ-016 SHALL use a single 4-byte S-box path (one SubWord per cycle); S-box contents per FIPS-197.
REQ-017 SHALL, on the edge that writes w[TOTAL-1], enter DONE, clear busy_o and set done_o; done_o asserts TOTAL-Nk clocks after the start edge (40/46/52 for 128/192/256).
REQ-018 SHALL hold done_o high in DONE until the next accepted start_i.
REQ-019 SHALL register the read: rk_o reflects rk_idx_i sampled at the previous edge (1-cycle latency), in every state.
REQ-020 SHALL drive rk_o to all zeros for rk_idx_i > Nr.
REQ-021 SHALL treat rk_o read during EXPAND as don't-care for words not yet written; already-written words SHALL read correctly.
REQ-022 SHALL, on a simultaneous start_i in DONE and a read, return the old schedule for the read that edge.

Reset
REQ-023 SHALL, on rst_n_i low at any time (including mid-EXPAND), immediately force state IDLE, busy_o=0, done_o=0, rk_o=0, i=0, Rcon=0x01.
REQ-024 SHALL NOT require clearing of the word storage by reset; contents are invalid until the next done_o.
REQ-025 SHALL require, after reset release, a new start_i before done_o can assert.

Verification
REQ-026 SHALL cover this scenario: KEY_WIDTH=128, key 2b7e151628aed2a6abf7158809cf4f3c -> done_o at +40 clocks; rk 1 = a0fafe1788542cb123a339392a6c7605; rk 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; rk 0 = key.
REQ-027 SHALL cover this scenario: KEY_WIDTH=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done_o at +46 clocks; rk 12 = e98ba06f448c773c8ecc720401002202.
REQ-028 SHALL cover this scenario: KEY_WIDTH=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done_o at +52 clocks; rk 14 = fe4890d1e6188d0b046df344706c631e.
REQ-029 SHALL cover this scenario: start_i pulsed again at +10 clocks during EXPAND (128) -> ignored; done_o still at +40; rk 10 unchanged from REQ-026.
REQ-030 SHALL cover this scenario: rst_n_i low at +20 clocks -> busy_o, done_o and rk_o 0 same cycle; restart with REQ-026 key -> REQ-026 results.
REQ-031 SHALL cover this scenario: rk_idx_i=15 with KEY_WIDTH=128 in DONE -> rk_o=0 next cycle; back-to-back start in DONE with a new key -> done_o drops next cycle, new schedule after 40.
